// File: rtl/spi_axil_slave.sv
// AXI4-Lite register front end for the SPI master: mode/select control, byte launch, receive capture.
// Optional interrupt output and CR.IE bit are built when SPI_AXIL_IRQ_EN is defined.
module spi_axil_slave #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [31:0]           s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [31:0]           s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  CPOL,
   output logic                  CPHA,
   output logic                  start,
   output logic [7:0]            tx_data,
   input  logic [7:0]            rx_data,
   input  logic                  done,
   input  logic                  ready,
`ifdef SPI_AXIL_IRQ_EN
   output logic                  irq,
`endif
   output logic                  SS
);

   typedef enum logic {C_IDLE, C_WAIT} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_cpol, r_cpha, r_ss_en, r_ie;
   logic [7:0]  r_tdr, r_rdr, r_tx_data;
   logic        r_tx_pending, r_rx_valid, r_overrun, r_start;
   logic        r_bvalid, r_rvalid;
   logic [1:0]  r_bresp;
   logic [31:0] r_rdata, w_rdata;
   logic        w_launch, w_capture, w_busy;
   logic        w_wr_hs, w_rd_hs, w_wr_en, w_wr_err;
   logic        w_cr_wr, w_tdr_wr, w_sr_wr, w_rdr_rd;
   logic [1:0]  w_waddr, w_raddr;
   logic        w_unused;

   assign w_waddr  = s_awaddr[3:2];
   assign w_raddr  = s_araddr[3:2];
   assign w_busy   = (r_state == C_WAIT);
   assign w_wr_hs  = s_awvalid & s_wvalid & ~r_bvalid;
   assign w_rd_hs  = s_arvalid & ~r_rvalid;
   assign w_wr_en  = w_wr_hs & s_wstrb[0];
   assign w_cr_wr  = w_wr_en & (w_waddr == 2'd0);
   assign w_tdr_wr = w_wr_en & (w_waddr == 2'd1) & ~r_tx_pending;
   assign w_sr_wr  = w_wr_en & (w_waddr == 2'd3);
   assign w_rdr_rd = w_rd_hs & (w_raddr == 2'd2);
   assign w_wr_err = w_wr_en & (((w_waddr == 2'd0) & w_busy) |
                                ((w_waddr == 2'd1) & r_tx_pending));
   assign w_unused = ^{s_awaddr, s_araddr, s_wdata, s_wstrb};

   assign s_awready = w_wr_hs;
   assign s_wready  = w_wr_hs;
   assign s_bvalid  = r_bvalid;
   assign s_bresp   = r_bresp;
   assign s_arready = w_rd_hs;
   assign s_rvalid  = r_rvalid;
   assign s_rdata   = r_rdata;
   assign s_rresp   = 2'b00;
   assign CPOL      = r_cpol;
   assign CPHA      = r_cpha;
   assign SS        = ~r_ss_en;
   assign start     = r_start;
   assign tx_data   = r_tx_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= C_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         C_IDLE: begin
            if (r_tx_pending & ready) begin
               w_launch    = 1'b1;
               w_state_nxt = C_WAIT;
            end
         end
         C_WAIT: begin
            if (done) begin
               w_capture   = 1'b1;
               w_state_nxt = C_IDLE;
            end
         end
         default: w_state_nxt = C_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      unique case (w_raddr)
         2'd0: w_rdata[3:0] = {r_ie, r_ss_en, r_cpha, r_cpol};
         2'd1: w_rdata[7:0] = r_tdr;
         2'd2: w_rdata[7:0] = r_rdr;
         2'd3: w_rdata[3:0] = {r_overrun, r_tx_pending, r_rx_valid, w_busy};
         default: w_rdata = '0;
      endcase
   end

`ifdef SPI_AXIL_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ie <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (w_cr_wr) r_ie <= s_wdata[3];
         irq <= r_ie & (r_rx_valid | r_overrun);
      end
   end
`else
   assign r_ie = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpol       <= 1'b0;
         r_cpha       <= 1'b0;
         r_ss_en      <= 1'b0;
         r_tdr        <= '0;
         r_rdr        <= '0;
         r_tx_data    <= '0;
         r_tx_pending <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_overrun    <= 1'b0;
         r_start      <= 1'b0;
         r_bvalid     <= 1'b0;
         r_bresp      <= 2'b00;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_start <= w_launch;
         // tx_data is a private copy so a TDR write during a transfer cannot disturb the master
         if (w_launch) r_tx_data <= r_tdr;
         if (w_launch)      r_tx_pending <= 1'b0;
         else if (w_tdr_wr) r_tx_pending <= 1'b1;
         if (w_tdr_wr) r_tdr <= s_wdata[7:0];
         if (w_cr_wr) begin
            r_ss_en <= s_wdata[2];
            if (!w_busy) begin
               r_cpol <= s_wdata[0];
               r_cpha <= s_wdata[1];
            end
         end
         if (w_capture) r_rdr <= rx_data;
         if (w_capture)      r_rx_valid <= 1'b1;
         else if (w_rdr_rd)  r_rx_valid <= 1'b0;
         if (w_capture & r_rx_valid & ~w_rdr_rd) r_overrun <= 1'b1;
         else if (w_sr_wr & s_wdata[3])          r_overrun <= 1'b0;
         if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
         end else if (s_bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
         end else if (s_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_axil_slave.sv
// Scoreboard bench for spi_axil_slave: directed AXI-Lite traffic and a hand-driven SPI master model.
module tb_spi_axil_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  s_awaddr = '0, s_araddr = '0;
   logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1;
   logic        s_arvalid = 1'b0, s_rready = 1'b1;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic        CPOL, CPHA, start, SS;
   logic [7:0]  tx_data, rx_data = '0;
   logic        done = 1'b0, ready = 1'b1;
`ifdef SPI_AXIL_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;

   logic [1:0]  bq[$];
   logic [31:0] rq[$];
   logic [7:0]  txq[$];
   bit          latq[$];
   int          since = 100;
   logic        prev_start = 1'b0;

   localparam logic [3:0] CR = 4'h0, TDR = 4'h4, RDR = 4'h8, SR = 4'hC;

   spi_axil_slave #(.ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .CPOL(CPOL), .CPHA(CPHA), .start(start), .tx_data(tx_data),
      .rx_data(rx_data), .done(done), .ready(ready),
`ifdef SPI_AXIL_IRQ_EN
      .irq(irq),
`endif
      .SS(SS)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: sampled on the falling edge, handshakes complete on the next rising edge.
   always @(negedge clk) begin
      if (s_bvalid && s_bready) begin
         if (bq.size() == 0) chk("b_unexpected", 32'(s_bresp), 32'hFFFF_FFFF);
         else chk("bresp", 32'(s_bresp), 32'(bq.pop_front()));
      end
      if (s_rvalid && s_rready) begin
         if (rq.size() == 0) chk("r_unexpected", s_rdata, 32'hFFFF_FFFF);
         else chk("rdata_rresp", {s_rresp, s_rdata[29:0]}, {2'b00, rq.pop_front()});
      end
      if (s_awvalid && s_awready && s_awaddr[3:2] == 2'd1) since = 0;
      else since = since + 1;
      if (start) begin
         chk("start_width", 32'(prev_start), 32'h0);
         if (txq.size() == 0) chk("start_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
         else begin
            chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
            if (latq.pop_front()) chk("start_latency", 32'(since), 32'd2);
         end
      end
      prev_start = start;
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb,
                     input logic [1:0] resp, input bit wait_b);
      int n;
      bq.push_back(resp);
      s_awaddr = a; s_wdata = d; s_wstrb = strb;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_awready) begin
         n++;
         if (n > 50) begin
            chk("aw_timeout", 32'(s_awready), 32'h1);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      if (wait_b) begin
         n = 0;
         while (bq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (bq.size() != 0) begin
            chk("b_timeout", 32'(bq.size()), 32'h0);
            bq.delete();
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      int n;
      rq.push_back(exp);
      s_araddr = a; s_arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_arready) begin
         n++;
         if (n > 50) begin
            chk("ar_timeout", 32'(s_arready), 32'h1);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      n = 0;
      while (rq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0) begin
         chk("r_timeout", 32'(rq.size()), 32'h0);
         rq.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic master_done(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b; done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
   endtask

   task automatic expect_tx(input logic [7:0] b, input bit lat);
      txq.push_back(b);
      latq.push_back(lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_SS", 32'(SS), 32'h1);
      chk("rst_start", 32'(start), 32'h0);
      chk("rst_mode", {30'h0, CPHA, CPOL}, 32'h0);
      chk("rst_valids", {29'h0, s_bvalid, s_rvalid, s_awready}, 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      @(posedge clk); #1;
      rd(CR, 32'h0); rd(TDR, 32'h0); rd(RDR, 32'h0); rd(SR, 32'h0);

      // Basic transfer
      wr(CR, 32'h7, 4'hF, 2'b00, 1);
      chk("mode_ss", {29'h0, SS, CPHA, CPOL}, 32'h3);
      expect_tx(8'hA5, 1);
      wr(TDR, 32'hA5, 4'hF, 2'b00, 1);
      rd(SR, 32'h1);
      master_done(8'h3C);
      rd(SR, 32'h2);
      rd(RDR, 32'h3C);
      rd(SR, 32'h0);

      // Overrun
      expect_tx(8'h11, 1);
      wr(TDR, 32'h11, 4'hF, 2'b00, 1);
      repeat (2) @(posedge clk);
      master_done(8'h55);
      expect_tx(8'h22, 1);
      wr(TDR, 32'h22, 4'hF, 2'b00, 1);
      repeat (2) @(posedge clk);
      master_done(8'h66);
      rd(SR, 32'hA);
      rd(RDR, 32'h66);
      rd(SR, 32'h8);
      wr(SR, 32'h8, 4'hF, 2'b00, 1);
      rd(SR, 32'h0);

      // Error responses
      ready = 1'b0;
      expect_tx(8'h33, 0);
      wr(TDR, 32'h33, 4'hF, 2'b00, 1);
      wr(TDR, 32'h44, 4'hF, 2'b10, 1);
      rd(TDR, 32'h33);
      rd(SR, 32'h4);
      wr(TDR, 32'h99, 4'h0, 2'b00, 1);
      rd(TDR, 32'h33);
      ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      rd(SR, 32'h1);
      wr(CR, 32'h0, 4'hF, 2'b10, 1);
      chk("busy_cr_mode_ss", {29'h0, SS, CPHA, CPOL}, 32'h7);
      rd(CR, 32'h3);
      master_done(8'h77);
      rd(RDR, 32'h77);
      rd(SR, 32'h0);

      // Back-pressure on B
      s_bready = 1'b0;
      wr(CR, 32'h5, 4'hF, 2'b00, 0);
      s_awaddr = CR; s_wdata = 32'h1; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_ready", {30'h0, s_awready, s_wready}, 32'h0);
         chk("hold_bvalid", 32'(s_bvalid), 32'h1);
      end
      @(posedge clk); #1;
      s_bready = 1'b1;
      wr(CR, 32'h1, 4'hF, 2'b00, 1);
      chk("final_mode_ss", {29'h0, SS, CPHA, CPOL}, 32'h5);
      rd(CR, 32'h1);
      chk("tx_all_started", 32'(txq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
